// File: rtl/vector_issue_queue.sv
// vector_issue_queue
// Buffers 32-bit vector instructions from the host interface and issues them
// one at a time to the combinational decoder. Issue is held while a
// multi-cycle operation (load, store, floating point) is executing, and
// released by a one-cycle exec_done pulse. FIFO status and a wrapping issue
// counter are exposed for host polling.

module vector_issue_queue #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              in_instr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     stall,
   input  logic                     exec_done,
   input  logic                     flush,
   output logic [31:0]              instruction,
   output logic                     instruction_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     busy,
   output logic [CNT_W-1:0]         issued_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

   // Opcodes (instr[31:27]) that occupy the datapath for several cycles:
   // VLOAD, VSTORE, VFADD, VFSUB, VFMUL.
   localparam int            NUM_MC = 5;
   localparam logic [24:0]   MC_OPS = {5'b00000, 5'b00001, 5'b00111, 5'b10000, 5'b01000};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------
   logic [31:0]       mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W:0]    count_reg;
   logic [PTR_W:0]    count_next;

   state_t            state_reg;
   logic [31:0]       instruction_reg;
   logic              valid_reg;
   logic              busy_reg;
   logic [CNT_W-1:0]  issued_count_reg;

   logic              push;
   logic              pop;
   logic              can_issue;
   logic              issued_is_mc;
   logic [NUM_MC-1:0] mc_match;
   logic [31:0]       head;

   // ------------------------------------------------------------------
   // Status and handshake
   // ------------------------------------------------------------------
   assign full      = (count_reg == DEPTH_CNT);
   assign empty     = (count_reg == '0);
   assign in_ready  = !full && !flush && !reset;
   assign push      = in_valid && in_ready;
   assign can_issue = !empty && !stall;

   // Head is read asynchronously so the issue edge can register it directly;
   // otherwise a registered read would add a cycle to every issue.
   assign head = mem[rd_ptr_reg];

   // Classify the word currently presented to the decoder.
   generate
      for (genvar gi = 0; gi < NUM_MC; gi++) begin : g_mc
         assign mc_match[gi] = (instruction_reg[31:27] == MC_OPS[gi*5 +: 5]);
      end
   endgenerate
   assign issued_is_mc = |mc_match;

   // Decide whether the head is popped and issued this cycle.
   always_comb begin
      pop = 1'b0;
      case (state_reg)
         S_IDLE:  pop = can_issue;
         S_ISSUE: pop = can_issue && !issued_is_mc;
         default: pop = 1'b0;
      endcase
      if (flush) begin
         pop = 1'b0;
      end
   end

   // Occupancy update; a push is never accepted while full, so a same-cycle
   // pop cannot make room for it.
   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // FIFO storage write; contents need no reset since pointers gate them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= in_instr;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
      end
   end

   // Issue FSM: registers the popped word, pulses valid, and parks in WAIT
   // after a multi-cycle op until exec_done. Flush leaves issued_count alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= S_IDLE;
         instruction_reg  <= '0;
         valid_reg        <= 1'b0;
         busy_reg         <= 1'b0;
         issued_count_reg <= '0;
      end else if (flush) begin
         state_reg <= S_IDLE;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               busy_reg <= 1'b0;
               if (pop) begin
                  instruction_reg  <= head;
                  valid_reg        <= 1'b1;
                  issued_count_reg <= issued_count_reg + 1'b1;
                  state_reg        <= S_ISSUE;
               end else begin
                  valid_reg <= 1'b0;
               end
            end
            S_ISSUE: begin
               if (issued_is_mc) begin
                  valid_reg <= 1'b0;
                  busy_reg  <= 1'b1;
                  state_reg <= S_WAIT;
               end else if (pop) begin
                  instruction_reg  <= head;
                  valid_reg        <= 1'b1;
                  issued_count_reg <= issued_count_reg + 1'b1;
               end else begin
                  valid_reg <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end
            S_WAIT: begin
               valid_reg <= 1'b0;
               if (exec_done) begin
                  busy_reg  <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end
            default: begin
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign instruction       = instruction_reg;
   assign instruction_valid = valid_reg;
   assign count             = count_reg;
   assign busy              = busy_reg;
   assign issued_count      = issued_count_reg;

endmodule

// File: tb/tb_vector_issue_queue.sv
// Scoreboard bench for vector_issue_queue: stimulus queues expected issues
// (word and, where known, the cycle it must appear); a monitor on the falling
// edge pops and compares every instruction_valid pulse.

module tb_vector_issue_queue;

   localparam int DEPTH = 8;
   localparam int CNT_W = 16;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [31:0]            in_instr;
   logic                   in_valid;
   logic                   in_ready;
   logic                   stall;
   logic                   exec_done;
   logic                   flush;
   logic [31:0]            instruction;
   logic                   instruction_valid;
   logic [$clog2(DEPTH):0] count;
   logic                   full;
   logic                   empty;
   logic                   busy;
   logic [CNT_W-1:0]       issued_count;

   vector_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .reset             (reset),
      .in_instr          (in_instr),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .stall             (stall),
      .exec_done         (exec_done),
      .flush             (flush),
      .instruction       (instruction),
      .instruction_valid (instruction_valid),
      .count             (count),
      .full              (full),
      .empty             (empty),
      .busy              (busy),
      .issued_count      (issued_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] word;
      int          at;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   exp_issued = 0;

   // Monitor: every issue pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && instruction_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue: got instruction=%h at cycle %0d, required no issue", instruction, cyc);
         end else begin
            e = sb.pop_front();
            if (instruction !== e.word || (e.at >= 0 && cyc != e.at)) begin
               errors++;
               $display("FAIL issue: got %h at cycle %0d, required %h at cycle %0d", instruction, cyc, e.word, e.at);
            end else begin
               $display("issue %h at cycle %0d", instruction, cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, req);
      end else begin
         $display("check %s = %0h", name, got);
      end
   endtask

   // Drive one push for a cycle; an expected issue lands two edges later
   // when the queue is empty and idle (lat=2), or is timed later (lat<0).
   task automatic push(input logic [31:0] w, input bit expect_issue, input int lat);
      exp_t e;
      in_instr = w;
      in_valid = 1'b1;
      if (expect_issue) begin
         e.word = w;
         e.at   = (lat >= 0) ? cyc + lat : -1;
         sb.push_back(e);
         exp_issued++;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while (sb.size() != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check("drain_empty_scoreboard", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      in_instr  = '0;
      in_valid  = 1'b0;
      stall     = 1'b0;
      exec_done = 1'b0;
      flush     = 1'b0;
      #1 reset = 1'b1;
      #2;
      // Reset values
      check("rst_valid", instruction_valid, 0);
      check("rst_instruction", instruction, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_issued", issued_count, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1 check("in_ready_after_reset", in_ready, 1);
      @(negedge clk);

      // exec_done while idle is ignored
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      check("exec_done_idle_busy", busy, 0);

      // Single VADD, two-edge latency
      push(32'h10A20000, 1'b1, 2);
      drain(20);
      check("single_issued", issued_count, exp_issued);
      check("single_count", count, 0);
      check("single_empty", empty, 1);

      // Three back-to-back words, one per cycle
      push(32'h10A20001, 1'b1, 2);
      push(32'h10A20002, 1'b1, 2);
      push(32'h10A20003, 1'b1, 2);
      drain(20);
      check("b2b_issued", issued_count, exp_issued);
      check("b2b_empty", empty, 1);
      check("hold_instruction", instruction, 32'h10A20003);
      check("hold_valid_low", instruction_valid, 0);

      // VLOAD holds issue until exec_done
      push(32'h00200000, 1'b1, 2);
      push(32'h10A20010, 1'b1, -1);
      repeat (4) @(negedge clk);
      check("wait_busy", busy, 1);
      check("wait_count", count, 1);
      check("wait_no_issue", sb.size(), 1);
      exec_done = 1'b1;
      sb[0].at = cyc + 2;
      @(negedge clk);
      exec_done = 1'b0;
      drain(20);
      check("after_wait_busy", busy, 0);
      check("after_wait_issued", issued_count, exp_issued);

      // Fill under stall; ninth push dropped, then drain in order
      stall = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         push(32'h10B20000 + i, 1'b1, -1);
      end
      check("fill_full", full, 1);
      check("fill_count", count, DEPTH);
      check("fill_in_ready", in_ready, 0);
      push(32'h1DEAD000, 1'b0, -1);
      check("fill_count_after_9th", count, DEPTH);
      stall = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         sb[i].at = cyc + 1 + i;
      end
      drain(40);
      check("fill_issued", issued_count, exp_issued);
      check("fill_empty", empty, 1);

      // Flush with five queued and a simultaneous push
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push(32'h10E20000 + i, 1'b0, -1);
      end
      check("pre_flush_count", count, 5);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h1BAD0000;
      #1 check("flush_in_ready", in_ready, 0);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_count", count, 0);
      check("flush_empty", empty, 1);
      check("flush_valid", instruction_valid, 0);
      check("flush_issued", issued_count, exp_issued);
      stall = 1'b0;
      repeat (6) @(negedge clk);

      // Reset while in WAIT with four queued
      push(32'h08000000, 1'b1, 2);
      for (int i = 0; i < 4; i++) begin
         push(32'h10C20000 + i, 1'b0, -1);
      end
      repeat (2) @(negedge clk);
      check("pre_reset_busy", busy, 1);
      check("pre_reset_count", count, 4);
      reset = 1'b1;
      exp_issued = 0;
      #1;
      check("midrst_valid", instruction_valid, 0);
      check("midrst_instruction", instruction, 0);
      check("midrst_count", count, 0);
      check("midrst_empty", empty, 1);
      check("midrst_busy", busy, 0);
      check("midrst_issued", issued_count, 0);
      check("midrst_in_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("post_reset_empty", empty, 1);

      push(32'h10A2FFFF, 1'b1, 2);
      drain(20);
      check("post_reset_issued", issued_count, exp_issued);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
